vga_scan: RTL and testbench

VGA_SCAN -- requirements
Module: vga_scan

---
 rtl/vga_scan_pkg.sv | 41 ++++
 rtl/vga_scan_sync_counter.sv | 27 ++
 rtl/vga_scan.sv | 108 ++++++++++
 tb/tb_vga_scan.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_scan_pkg.sv
// Shared display package: default 640x480@60 timing, counter types and colour
// field positions used by both the scan generator and the pixel renderer.
package vga_scan_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Colour word layout {R, G, B}, 4 bits each
  localparam int unsigned RGB_W = 12;
  localparam int unsigned R_HI  = 11;
  localparam int unsigned R_LO  = 8;
  localparam int unsigned G_HI  = 7;
  localparam int unsigned G_LO  = 4;
  localparam int unsigned B_HI  = 3;
  localparam int unsigned B_LO  = 0;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  // Half-open window test: lo <= cnt < hi
  function automatic logic in_window(input cnt_t cnt, input cnt_t lo, input cnt_t hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_scan_sync_counter.sv
// Modulo-N enabled counter; wrap is asserted combinationally on the enabled
// cycle that takes the count from MODULUS-1 back to zero.
module sync_counter
  import vga_scan_pkg::*;
#(
  parameter int unsigned MODULUS = VGA_H_TOTAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output cnt_t count,
  output logic wrap
);

  localparam cnt_t LAST = cnt_t'(MODULUS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + cnt_t'(1);
    end
  end

  assign wrap = en && (count == LAST);

endmodule

// File: rtl/vga_scan.sv
// VGA scan generator: pixel-rate divider, horizontal/vertical counters and a
// registered colour/sync output stage one pixel period behind col/row.
module vga_scan
  import vga_scan_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned PIX_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  col,
  output logic [9:0]  row,
  input  logic [11:0] rgb_in,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hs,
  output logic        vs,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_ACT_C = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SS    = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SE    = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_SS    = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SE    = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0] div_cnt;
  logic       pix_en;
  cnt_t       h_cnt;
  cnt_t       v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       active;
  rgb_t       pix_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  assign pix_en = (div_cnt == DIV_LAST);

  sync_counter #(.MODULUS(H_TOTAL)) u_h_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  // Vertical advances only on the pixel that ends a line
  sync_counter #(.MODULUS(V_TOTAL)) u_v_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  assign col = h_cnt;
  assign row = v_cnt;

  always_comb begin
    active  = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    pix_rgb = active ? rgb_in : '0;
  end

  // Output stage samples the pre-increment counts, so colour and sync stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_wrap;
      if (pix_en) begin
        vga_r <= pix_rgb[R_HI:R_LO];
        vga_g <= pix_rgb[G_HI:G_LO];
        vga_b <= pix_rgb[B_HI:B_LO];
        hs    <= !in_window(h_cnt, H_SS, H_SE);
        vs    <= !in_window(v_cnt, V_SS, V_SE);
      end
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: default timing (PIX_DIV 4 and 2) plus a shrunken
// timing instance so whole frames, vsync and mid-frame reset fit in a short run.
module tb_vga_scan;

  typedef struct {
    int pd;
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    int hs_clk, vs_clk, line_clk, frame_clk;
  } tim_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  typedef struct packed {
    logic [9:0]  col;
    logic [9:0]  row;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } obs_t;

  typedef struct {
    int          d;
    int          k;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n, rst2_n;
  logic [9:0]  col0, row0, col1, row1, col2, row2;
  logic [11:0] rgb0, rgb1, rgb2;
  logic [3:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic        hs0, vs0, fs0, hs1, vs1, fs1, hs2, vs2, fs2;

  vga_scan #(.PIX_DIV(4)) dut0 (
    .clk(clk), .rst_n(rst0_n), .col(col0), .row(row0), .rgb_in(rgb0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .hs(hs0), .vs(vs0), .frame_start(fs0)
  );

  vga_scan #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_DIV(2)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .col(col1), .row(row1), .rgb_in(rgb1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .hs(hs1), .vs(vs1), .frame_start(fs1)
  );

  vga_scan #(.PIX_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .col(col2), .row(row2), .rgb_in(rgb2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2), .hs(hs2), .vs(vs2), .frame_start(fs2)
  );

  // Renderers: dut0 has a 2-clk pipeline (or a flat colour), dut1 is combinational
  int          mode [3];
  logic [11:0] pipe_a, pipe_b;
  always @(posedge clk) begin
    pipe_a <= {col0[3:0], row0[3:0], 4'h5};
    pipe_b <= pipe_a;
  end
  assign rgb0 = (mode[0] == 1) ? pipe_b : 12'hF0A;
  assign rgb1 = {col1[3:0], row1[3:0], 4'h5};
  assign rgb2 = 12'h000;

  int     n_checks = 0;
  int     n_fail   = 0;
  tim_t   tim [3];
  int     kk [3];
  exp_t   held [3];
  exp_t   sb [$];
  vec_t   vecs [$];
  int     hs_run, vs_run, last_fs, last_line, last_col;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic obs_t observe(input int d);
    case (d)
      0:       return {col0, row0, r0, g0, b0, hs0, vs0, fs0};
      1:       return {col1, row1, r1, g1, b1, hs1, vs1, fs1};
      default: return {col2, row2, r2, g2, b2, hs2, vs2, fs2};
    endcase
  endfunction

  function automatic logic [11:0] pattern(input int d, input int h, input int v);
    logic [31:0] hh, vv;
    hh = h;
    vv = v;
    case (mode[d])
      0:       return 12'hF0A;
      1:       return {hh[3:0], vv[3:0], 4'h5};
      default: return 12'h000;
    endcase
  endfunction

  task automatic set_rst(input int d, input logic val);
    case (d)
      0:       rst0_n = val;
      1:       rst1_n = val;
      default: rst2_n = val;
    endcase
  endtask

  // Asserts reset mid-cycle, checks the asynchronous reset state, releases on a falling edge
  task automatic do_reset(input int d);
    obs_t o;
    set_rst(d, 1'b0);
    #1;
    o = observe(d);
    check("rst_col", 32'(o.col), 32'd0);
    check("rst_row", 32'(o.row), 32'd0);
    check("rst_rgb", 32'(o.rgb), 32'h000);
    check("rst_hs",  32'(o.hs),  32'd1);
    check("rst_vs",  32'(o.vs),  32'd1);
    check("rst_fs",  32'(o.fs),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_rst(d, 1'b1);
    kk[d]     = 0;
    held[d]   = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
    sb.delete();
    hs_run    = 0;
    vs_run    = 0;
    last_fs   = -1;
    last_line = -1;
    last_col  = 0;
  endtask

  // Advances nclk clocks; expected outputs are queued on each pixel edge, popped after it
  task automatic run(input int d, input int nclk);
    tim_t t;
    obs_t o;
    exp_t e;
    int   k, n, h, v, ht, vt, hss, vss;
    t   = tim[d];
    ht  = t.ha + t.hfp + t.hsw + t.hbp;
    vt  = t.va + t.vfp + t.vsw + t.vbp;
    hss = t.ha + t.hfp;
    vss = t.va + t.vfp;
    for (int i = 0; i < nclk; i++) begin
      @(posedge clk);
      kk[d]++;
      k = kk[d];
      if (k % t.pd == 0) begin
        n = k / t.pd - 1;
        h = n % ht;
        v = (n / ht) % vt;
        e.rgb = (h < t.ha && v < t.va) ? pattern(d, h, v) : 12'h000;
        e.hs  = !(h >= hss && h < hss + t.hsw);
        e.vs  = !(v >= vss && v < vss + t.vsw);
        sb.push_back(e);
      end
      #1;
      o = observe(d);
      check("col", 32'(o.col), 32'((k / t.pd) % ht));
      check("row", 32'(o.row), 32'(((k / t.pd) / ht) % vt));
      check("frame_start", 32'(o.fs), 32'((k % t.pd == 0) && ((k / t.pd) % (ht * vt) == 0)));
      if (sb.size() > 0) held[d] = sb.pop_front();
      check("rgb", 32'(o.rgb), 32'(held[d].rgb));
      check("hs",  32'(o.hs),  32'(held[d].hs));
      check("vs",  32'(o.vs),  32'(held[d].vs));
      if (!o.hs) hs_run++;
      else begin
        if (hs_run > 0) check("hs_width_clks", 32'(hs_run), 32'(t.hs_clk));
        hs_run = 0;
      end
      if (!o.vs) vs_run++;
      else begin
        if (vs_run > 0) check("vs_width_clks", 32'(vs_run), 32'(t.vs_clk));
        vs_run = 0;
      end
      if (o.fs) begin
        if (last_fs >= 0) check("frame_period_clks", 32'(k - last_fs), 32'(t.frame_clk));
        last_fs = k;
      end
      if (o.col == 10'd0 && last_col != 0) begin
        if (last_line >= 0) check("line_period_clks", 32'(k - last_line), 32'(t.line_clk));
        last_line = k;
      end
      last_col = int'(o.col);
    end
  endtask

  task automatic addv(input int d, input int k, input int c, input int r,
                      input logic [11:0] rgb, input logic h, input logic v, input logic f);
    vecs.push_back('{d: d, k: k, col: 10'(c), row: 10'(r), rgb: rgb, hs: h, vs: v, fs: f});
  endtask

  task automatic apply_vecs(input int d);
    obs_t o;
    foreach (vecs[i]) begin
      if (vecs[i].d == d) begin
        run(d, vecs[i].k - kk[d]);
        o = observe(d);
        check("vec_col", 32'(o.col), 32'(vecs[i].col));
        check("vec_row", 32'(o.row), 32'(vecs[i].row));
        check("vec_rgb", 32'(o.rgb), 32'(vecs[i].rgb));
        check("vec_hs",  32'(o.hs),  32'(vecs[i].hs));
        check("vec_vs",  32'(o.vs),  32'(vecs[i].vs));
        check("vec_fs",  32'(o.fs),  32'(vecs[i].fs));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    mode[0] = 0;
    mode[1] = 1;
    mode[2] = 2;
    tim[0] = '{pd: 4, ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33,
               hs_clk: 384, vs_clk: 6400, line_clk: 3200, frame_clk: 1680000};
    tim[1] = '{pd: 2, ha: 8, hfp: 2, hsw: 3, hbp: 2, va: 4, vfp: 1, vsw: 2, vbp: 1,
               hs_clk: 6, vs_clk: 60, line_clk: 30, frame_clk: 240};
    tim[2] = '{pd: 2, ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33,
               hs_clk: 192, vs_clk: 3200, line_clk: 1600, frame_clk: 840000};

    // dut0, flat F0A colour: k = clocks since release, values sampled 1 ns after edge k
    addv(0,    3,   0, 0, 12'h000, 1'b1, 1'b1, 1'b0);
    addv(0,    4,   1, 0, 12'hF0A, 1'b1, 1'b1, 1'b0);
    addv(0,    8,   2, 0, 12'hF0A, 1'b1, 1'b1, 1'b0);
    addv(0, 2560, 640, 0, 12'hF0A, 1'b1, 1'b1, 1'b0);
    addv(0, 2564, 641, 0, 12'h000, 1'b1, 1'b1, 1'b0);
    addv(0, 2624, 656, 0, 12'h000, 1'b1, 1'b1, 1'b0);
    addv(0, 2628, 657, 0, 12'h000, 1'b0, 1'b1, 1'b0);
    addv(0, 3008, 752, 0, 12'h000, 1'b0, 1'b1, 1'b0);
    addv(0, 3012, 753, 0, 12'h000, 1'b1, 1'b1, 1'b0);
    addv(0, 3200,   0, 1, 12'h000, 1'b1, 1'b1, 1'b0);
    addv(0, 3203,   0, 1, 12'h000, 1'b1, 1'b1, 1'b0);
    addv(0, 3204,   1, 1, 12'hF0A, 1'b1, 1'b1, 1'b0);
    // dut1, 15x8 timing, colour {col,row,5}
    addv(1,    2,   1, 0, 12'h005, 1'b1, 1'b1, 1'b0);
    addv(1,    4,   2, 0, 12'h105, 1'b1, 1'b1, 1'b0);
    addv(1,   30,   0, 1, 12'h000, 1'b1, 1'b1, 1'b0);
    addv(1,   32,   1, 1, 12'h015, 1'b1, 1'b1, 1'b0);
    addv(1,  240,   0, 0, 12'h000, 1'b1, 1'b1, 1'b1);
    addv(1,  241,   0, 0, 12'h000, 1'b1, 1'b1, 1'b0);

    #12;
    do_reset(0);
    apply_vecs(0);
    run(0, 9700 - kk[0]);

    mode[0] = 1;
    do_reset(0);
    run(0, 6500);
    set_rst(0, 1'b0);

    do_reset(1);
    apply_vecs(1);

    // Reset while both syncs are low (pixel h=11, v=6 just registered)
    do_reset(1);
    run(1, 204);
    o = observe(1);
    check("mid_col", 32'(o.col), 32'd12);
    check("mid_row", 32'(o.row), 32'd6);
    check("mid_hs",  32'(o.hs),  32'd0);
    check("mid_vs",  32'(o.vs),  32'd0);
    #2;
    do_reset(1);
    run(1, 800);
    set_rst(1, 1'b0);

    do_reset(2);
    run(2, 3300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
